main_mem_burst: RTL and testbench
=================================

Name: main_mem_burst

Overview:
- Backing main-memory stage directly downstream of the L1 data cache (`cache_fa_lru`); instantiated as `u_mem` inside the cache.
- Serves whole-line bursts:
  - line fill: memory -> cache, on `mem_wr`=0;
  - write-back: cache -> memory, on `mem_wr`=1.
- Bursts are sequences of 64-bit beats with a fixed programmable access latency.
- Holds the full 2^ADDR_BITS-byte address space.

Parameters:
- ADDR_BITS, 16, byte-address width; memory size is 2^ADDR_BITS bytes.
- BEAT_BYTES, 8, bytes per beat; data bus width is 8*BEAT_BYTES bits.
- LINE_BYTES, 64, bytes per burst; BEATS = LINE_BYTES/BEAT_BYTES = 8.
- RD_LAT, 4, cycles from burst accept to first read beat; legal range 1..15.
- WR_LAT, 2, cycles from burst accept to first write-beat acceptance; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- mem_req  input  1  burst request; the cache holds it high for the whole burst.
- mem_wr  input  1  direction: 1 = write-back, 0 = line fill; sampled at accept.
- mem_addr  input  ADDR_BITS  burst byte address; low log2(LINE_BYTES) bits ignored; sampled at accept.
- mem_wdata  input  8*BEAT_BYTES  write beat data.
- ready  output  1  write beat consumed this cycle.
- rvalid  output  1  read beat valid on rdata this cycle.
- rdata  output  8*BEAT_BYTES  read beat data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - On rst=0: state goes to IDLE; ready, rvalid, busy and rdata all 0; beat and latency counters cleared.
  - Storage contents are not cleared by reset; they are zero-initialised at time 0 only.
  - Reset mid-burst abandons the burst. Beats already written stay committed.
- State machine states: IDLE, LAT, RBURST, WBURST, DONE.
- IDLE:
  - When mem_req=1, latch base = mem_addr with the low bits zeroed, and latch wr = mem_wr.
  - Load the latency counter with (wr ? WR_LAT : RD_LAT) - 1, then go to LAT.
- LAT: count down to 0, then go to RBURST (wr=0) or WBURST (wr=1).
- RBURST:
  - One beat per cycle; beat k (k = 0..BEATS-1) comes from address base + k*BEAT_BYTES.
  - rvalid=1 with rdata registered in the same cycle.
  - After beat BEATS-1, go to DONE.
  - First rvalid occurs exactly RD_LAT+1 rising edges after the edge that sampled mem_req=1.
- WBURST:
  - ready=1 for one cycle per beat; the edge that sees ready=1 stores mem_wdata at base + k*BEAT_BYTES.
  - The cache must present beat k+1 in the cycle after it observes ready for beat k.
  - Consecutive ready pulses are separated by exactly one idle cycle (ready=0), so ready toggles.
  - After beat BEATS-1 is stored, go to DONE.
- DONE:
  - All outputs low except busy.
  - Stay in DONE while mem_req=1; go to IDLE on mem_req=0. A held request is never re-accepted.
- Abort: mem_req=0 in LAT, RBURST or WBURST goes to IDLE on the next edge. ready and rvalid are 0 from that edge onward.
- mem_addr and mem_wr changes after accept are ignored.
- Beat addresses never wrap: bursts are line-aligned, so the last line (0xFFC0..0xFFFF for 16-bit addressing) is legal and stays within the array.
- rdata holds its last value when rvalid=0.

Optional Feature:
- MAIN_MEM_RAND_STALL_EN
  - Defined: a 16-bit Galois LFSR (seed 16'hACE1, reloaded on reset) advances every cycle.
  - In RBURST/WBURST, a cycle where LFSR[0]=1 inserts a stall. That cycle has rvalid=0 / ready=0 and the beat index does not advance.
  - Burst order and data are unchanged; only beat timing varies.
  - Undefined: no LFSR; timing is exactly as described above.

Decomposition:
- Package mem_pkg:
  - BEAT_BYTES, LINE_BYTES, BEATS, and BEAT_IDX_W = log2(BEATS);
  - state enum { IDLE, LAT, RBURST, WBURST, DONE };
  - LFSR seed constant.
- One sub-module, mem_array_1rw: synchronous single-port array of 2^ADDR_BITS/BEAT_BYTES words of 8*BEAT_BYTES bits, one read or write per cycle, registered read data.
- The FSM and counters stay in main_mem_burst.

Test Plan:
- Preload 0x0040..0x007F with word k = 64'h1111_0000_0000_0000+k; fill at mem_addr=0x0047 -> 8 rvalid beats at base 0x0040, data k=0..7 in order, first beat RD_LAT+1 edges after accept.
- Write-back at 0x0100 with wdata = 64'hDEAD_0000+k per ready -> 8 ready pulses; a following fill of 0x0100 returns the same 8 values.
- Hold mem_req high for 20 cycles after a fill -> exactly 8 rvalid pulses, busy stays 1, no second burst.
- Drop mem_req after beat 3 of a write-back to 0x0200 -> idle on the next edge; a fill of 0x0200 returns beats 0..3 new and 4..7 old.
- Assert rst=0 asynchronously mid-RBURST -> ready, rvalid, busy and rdata all 0 immediately; after release, a fill of 0xFFC0 completes correctly.
- With MAIN_MEM_RAND_STALL_EN defined, repeat the first two tests -> identical data order, variable gaps between beats, beat count exactly 8.

Source files
------------

// File: rtl/main_mem_burst_pkg.sv
// mem_pkg: shared constants, FSM state type and stall-LFSR helper for main_mem_burst.
//   BEAT_BYTES/LINE_BYTES/BEATS/BEAT_IDX_W : default burst geometry
//   state_t                                : burst FSM states
//   LFSR_SEED/LFSR_TAPS, lfsr_next()       : 16-bit Galois LFSR used by the optional
//                                            random-stall build (MAIN_MEM_RAND_STALL_EN)
package mem_pkg;

  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned BEATS      = LINE_BYTES / BEAT_BYTES;
  localparam int unsigned BEAT_IDX_W = $clog2(BEATS);

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    LAT,
    RBURST,
    WBURST,
    DONE
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/main_mem_burst_if.sv
// main_mem_burst_if: cache <-> main-memory burst bus.
//   master (cache)  : drives mem_req, mem_wr, mem_addr, mem_wdata
//   slave  (memory) : drives ready, rvalid, rdata, busy
interface main_mem_burst_if #(
  parameter int unsigned ADDR_BITS  = 16,
  parameter int unsigned BEAT_BYTES = 8
);

  logic                      mem_req;
  logic                      mem_wr;
  logic [ADDR_BITS-1:0]      mem_addr;
  logic [8*BEAT_BYTES-1:0]   mem_wdata;
  logic                      ready;
  logic                      rvalid;
  logic [8*BEAT_BYTES-1:0]   rdata;
  logic                      busy;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  ready, rvalid, rdata, busy
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output ready, rvalid, rdata, busy
  );

endinterface

// File: rtl/main_mem_burst_mem_array_1rw.sv
// mem_array_1rw: synchronous single-port storage, one read or write per cycle.
//   clk, rst : clock; active-low async reset (clears only the read-data register)
//   en, we   : access enable; 1 = write, 0 = read
//   addr     : word address
//   wdata    : write word
//   rdata    : registered read word, holds its value between reads
module mem_array_1rw #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] store [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = store[addr];
  end

  always_ff @(posedge clk) begin
    if (en && we) store[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_burst.sv
// main_mem_burst: line-burst main memory behind the L1 data cache.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   mem  : main_mem_burst_if.slave (mem_req/mem_wr/mem_addr/mem_wdata in,
//          ready/rvalid/rdata/busy out)
// Build option: MAIN_MEM_RAND_STALL_EN inserts LFSR-driven beat stalls.
module main_mem_burst #(
  parameter int unsigned ADDR_BITS  = 16,
  parameter int unsigned BEAT_BYTES = mem_pkg::BEAT_BYTES,
  parameter int unsigned LINE_BYTES = mem_pkg::LINE_BYTES,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned WR_LAT     = 2
) (
  input  logic            clk,
  input  logic            rst,
  main_mem_burst_if.slave mem
);

  import mem_pkg::*;

  localparam int unsigned N_BEATS  = LINE_BYTES / BEAT_BYTES;
  localparam int unsigned IDX_W    = $clog2(N_BEATS);
  localparam int unsigned LOG_BEAT = $clog2(BEAT_BYTES);
  localparam int unsigned LOG_LINE = $clog2(LINE_BYTES);
  localparam int unsigned WORD_W   = ADDR_BITS - LOG_BEAT;
  localparam int unsigned LINE_W   = ADDR_BITS - LOG_LINE;
  localparam int unsigned DATA_W   = 8 * BEAT_BYTES;

  localparam logic [IDX_W:0] BEAT_END  = (IDX_W+1)'(N_BEATS);
  localparam logic [IDX_W:0] BEAT_LAST = (IDX_W+1)'(N_BEATS - 1);
  localparam logic [3:0]     RD_LOAD   = 4'(RD_LAT - 1);
  localparam logic [3:0]     WR_LOAD   = 4'(WR_LAT - 1);

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [3:0]          lat_q, lat_d;
  logic [IDX_W:0]      beat_q, beat_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;

  logic                stall;
  logic                arr_en, arr_we;
  logic [WORD_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_rdata;
  logic                addr_lo_unused;

  assign addr_lo_unused = ^mem.mem_addr[LOG_LINE-1:0];

`ifdef MAIN_MEM_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    line_d   = line_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    ready_d  = 1'b0;
    rvalid_d = 1'b0;
    arr_en   = 1'b0;
    arr_we   = 1'b0;
    arr_addr = {line_q, beat_q[IDX_W-1:0]};

    unique case (state_q)
      IDLE: begin
        if (mem.mem_req) begin
          line_d  = mem.mem_addr[ADDR_BITS-1 -: LINE_W];
          wr_d    = mem.mem_wr;
          lat_d   = mem.mem_wr ? WR_LOAD : RD_LOAD;
          beat_d  = '0;
          state_d = LAT;
        end
      end
      LAT: begin
        if (!mem.mem_req)      state_d = IDLE;
        else if (lat_q == '0)  state_d = wr_q ? WBURST : RBURST;
        else                   lat_d   = lat_q - 4'd1;
      end
      RBURST: begin
        // beat_q counts issued reads; rvalid trails the issue by one cycle,
        // so the burst ends in the cycle that presents the final beat.
        if (!mem.mem_req) begin
          state_d = IDLE;
        end else if (beat_q == BEAT_END) begin
          state_d = DONE;
        end else if (!stall) begin
          arr_en   = 1'b1;
          rvalid_d = 1'b1;
          beat_d   = beat_q + 1'b1;
        end
      end
      WBURST: begin
        // A visible ready commits the current mem_wdata on this edge.
        if (ready_q) begin
          arr_en = 1'b1;
          arr_we = 1'b1;
          beat_d = beat_q + 1'b1;
        end
        if (!mem.mem_req)                      state_d = IDLE;
        else if (ready_q && beat_q == BEAT_LAST) state_d = DONE;
        else if (!ready_q && !stall)           ready_d = 1'b1;
      end
      DONE: begin
        if (!mem.mem_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      line_q   <= '0;
      lat_q    <= '0;
      beat_q   <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      line_q   <= line_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
    end
  end

  mem_array_1rw #(
    .ADDR_W (WORD_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (mem.mem_wdata),
    .rdata (arr_rdata)
  );

  assign mem.ready  = ready_q;
  assign mem.rvalid = rvalid_q;
  assign mem.rdata  = arr_rdata;
  assign mem.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_burst.sv
module tb_main_mem_burst;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_mem_burst_if #(.ADDR_BITS(16), .BEAT_BYTES(8)) mif ();

  main_mem_burst #(
    .ADDR_BITS  (16),
    .BEAT_BYTES (8),
    .LINE_BYTES (64),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (mif)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q [$];
  int          rv_count = 0;
  int          first_rv_cyc = 0;

  logic [63:0] d11 [8];
  logic [63:0] ddead [8];
  logic [63:0] dold [8];
  logic [63:0] dnew [8];
  logic [63:0] dmix [8];
  logic [63:0] dffc [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every rvalid beat pops one expected word.
  always @(negedge clk) begin
    if (rst && mif.rvalid) begin
      if (rv_count == 0) first_rv_cyc = cyc;
      rv_count++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rdata_unexpected: got beat %h, required no beat", mif.rdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (mif.rdata !== e) begin
          n_bad++;
          $display("FAIL rdata_beat: got %h, required %h", mif.rdata, e);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (mif.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", mif.busy, 1'b0);
  endtask

  task automatic do_fill(input logic [15:0] addr, input logic [63:0] exp [8], input int hold);
    int acc;
    int n;
    for (int k = 0; k < 8; k++) exp_q.push_back(exp[k]);
    rv_count = 0;
    @(posedge clk); #1;
    mif.mem_req  = 1'b1;
    mif.mem_wr   = 1'b0;
    mif.mem_addr = addr;
    acc = cyc + 1;
    @(posedge clk); #1;
    mif.mem_addr = 16'h5555;
    mif.mem_wr   = 1'b1;
    n = 0;
    while (rv_count < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("fill_beats", 64'(rv_count), 64'd8);
`ifndef MAIN_MEM_RAND_STALL_EN
    chk("fill_latency", 64'(first_rv_cyc - acc), 64'(RD_LAT + 1));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_busy", mif.busy, 1'b1);
    end
    @(negedge clk);
    chk("fill_no_extra", 64'(rv_count), 64'd8);
    chk("fill_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    mif.mem_req = 1'b0;
    wait_idle();
  endtask

  task automatic do_wb(input logic [15:0] addr, input logic [63:0] data [8], input int stop_after);
    int k;
    int n;
    int last;
    k = 0;
    n = 0;
    last = -1;
    @(posedge clk); #1;
    mif.mem_req   = 1'b1;
    mif.mem_wr    = 1'b1;
    mif.mem_addr  = addr;
    mif.mem_wdata = data[0];
    while (k < stop_after && n < 300) begin
      @(negedge clk);
      n++;
      if (mif.ready) begin
`ifndef MAIN_MEM_RAND_STALL_EN
        if (last >= 0) chk("ready_gap", 64'(cyc - last), 64'd2);
`endif
        last = cyc;
        k++;
        @(posedge clk); #1;
        if (k < 8) mif.mem_wdata = data[k];
        mif.mem_addr = 16'hAAAA;
        if (k == stop_after) mif.mem_req = 1'b0;
      end
    end
    chk("wb_beats", 64'(k), 64'(stop_after));
    @(negedge clk);
    chk("wb_busy_before_idle", mif.busy, 1'b1);
    chk("wb_ready_low", mif.ready, 1'b0);
    @(negedge clk);
    chk("wb_idle_next_edge", mif.busy, 1'b0);
    mif.mem_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    for (int k = 0; k < 8; k++) begin
      d11[k]   = 64'h1111_0000_0000_0000 + 64'(k);
      ddead[k] = 64'h0000_0000_DEAD_0000 + 64'(k);
      dold[k]  = 64'h0000_0000_0BAD_0000 + 64'(k);
      dnew[k]  = 64'h0000_0000_BEEF_0000 + 64'(k);
      dmix[k]  = (k < 4) ? dnew[k] : dold[k];
      dffc[k]  = 64'hFFC0_0000_0000_0000 + 64'(k);
    end
    mif.mem_req   = 1'b0;
    mif.mem_wr    = 1'b0;
    mif.mem_addr  = '0;
    mif.mem_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", mif.ready, 1'b0);
    chk("rst_rvalid", mif.rvalid, 1'b0);
    chk("rst_busy", mif.busy, 1'b0);
    chk("rst_rdata", mif.rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Preload, then fill from an unaligned address in the same line.
    do_wb(16'h0040, d11, 8);
    do_fill(16'h0047, d11, 0);

    // Write-back then read-back with the request held long after the burst.
    do_wb(16'h0100, ddead, 8);
    do_fill(16'h0100, ddead, 20);

    // Aborted write-back keeps only the beats already stored.
    do_wb(16'h0200, dold, 8);
    do_wb(16'h0200, dnew, 4);
    do_fill(16'h0200, dmix, 0);

    // Top line of the address space, then async reset in the middle of a fill.
    do_wb(16'hFFC0, dffc, 8);
    for (int k = 0; k < 8; k++) exp_q.push_back(d11[k]);
    rv_count = 0;
    @(posedge clk); #1;
    mif.mem_req  = 1'b1;
    mif.mem_wr   = 1'b0;
    mif.mem_addr = 16'h0040;
    n = 0;
    while (rv_count < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_beats", 64'(rv_count), 64'd3);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_rst_ready", mif.ready, 1'b0);
    chk("async_rst_rvalid", mif.rvalid, 1'b0);
    chk("async_rst_busy", mif.busy, 1'b0);
    chk("async_rst_rdata", mif.rdata, 64'd0);
    exp_q.delete();
    mif.mem_req = 1'b0;
    @(negedge clk);
    chk("rst_hold_busy", mif.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_fill(16'hFFC0, dffc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
